// File: rtl/inst_prefetch_pkg.sv
// Shared widths, the queued {pc, inst} entry type and PC alignment for the prefetch unit.
package inst_prefetch_pkg;

    localparam int LEN_WORD         = 32;
    localparam int LEN_INST         = 32;
    localparam int LEN_MEMISTR_ADDR = 15;

    typedef struct packed {
        logic [LEN_WORD-1:0] pc;
        logic [LEN_INST-1:0] inst;
    } fetch_entry_t;

    // Instruction fetch is word based; the low two byte-address bits are dropped.
    function automatic logic [LEN_WORD-1:0] align_pc(input logic [LEN_WORD-1:0] x);
        return x & {{(LEN_WORD-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO with a registered head word; flush empties it in one cycle.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [AW:0]      remain;
    logic [WIDTH-1:0] head_reg;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign count     = count_reg;
    assign head_data = head_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        remain      = count_reg - (AW+1)'(do_pop);
        count_next  = remain + (AW+1)'(push);
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Head register tracks the entry that will be at the front next cycle;
    // when nothing older remains it takes the word being pushed.
    always_ff @(posedge clk) begin
        if (push && rstn && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
        head_reg <= (remain == '0) ? push_data : mem[rd_ptr_next];
    end

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: credit-limited issue, fixed-latency tag pipe, decode queue.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          MEM_LATENCY = 2,
    parameter int          IADDR_W     = LEN_MEMISTR_ADDR,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [IADDR_W-1:0]       a_inst,
    input  logic [31:0]              d_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LEN_WORD-1:0]    fetch_pc_reg;
    logic [LEN_WORD-1:0]    fetch_pc_next;
    logic [MEM_LATENCY-1:0] sr_valid_reg;
    logic [LEN_WORD-1:0]    sr_pc_reg [MEM_LATENCY];

    logic         pop;
    logic         issue;
    logic         exit_valid;
    logic         q_push;
    logic         q_empty;
    logic         q_full;
    logic [CW-1:0] q_count;
    fetch_entry_t q_push_data;
    fetch_entry_t q_head;
    int           inflight;
    int           occupancy;

    assign pop       = out_valid & out_ready;
    assign out_valid = ~q_empty;
    assign out_pc    = q_head.pc;
    assign out_inst  = q_head.inst;
    assign count     = q_count;
    assign a_inst    = fetch_pc_reg[IADDR_W+1:2];

    // Every read in flight already owns a queue slot, so the capture side can never overflow.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight += int'(sr_valid_reg[i]);
        end
        occupancy = int'(q_count) + inflight - int'(pop);
        issue     = ~redirect & (occupancy < DEPTH);
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect) begin
            fetch_pc_next = align_pc(redirect_pc);
        end else if (issue) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_reg <= RESET_PC;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // Tag pipe: stage k holds the read issued k+1 cycles ago.
    always_ff @(posedge clk) begin
        if (!rstn || redirect) begin
            sr_valid_reg <= '0;
        end else begin
            sr_valid_reg[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                sr_valid_reg[i] <= sr_valid_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        sr_pc_reg[0] <= fetch_pc_reg;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            sr_pc_reg[i] <= sr_pc_reg[i-1];
        end
    end

    assign exit_valid       = sr_valid_reg[MEM_LATENCY-1];
    assign q_push           = exit_valid & ~redirect & (~q_full | pop);
    assign q_push_data.pc   = sr_pc_reg[MEM_LATENCY-1];
    assign q_push_data.inst = d_inst;

    inst_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (pop),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: scoreboard of expected {pc, inst} drained by an output monitor.
module tb_inst_prefetch;

    localparam int DEPTH   = 4;
    localparam int LAT     = 2;
    localparam int IADDR_W = 15;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [31:0]            out_inst;
    logic [IADDR_W-1:0]     a_inst;
    logic [31:0]            d_inst;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    inst_prefetch #(
        .DEPTH       (DEPTH),
        .MEM_LATENCY (LAT),
        .IADDR_W     (IADDR_W),
        .RESET_PC    (32'h0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .a_inst      (a_inst),
        .d_inst      (d_inst),
        .count       (count)
    );

    // Instruction memory model: address sampled at each edge, data LAT cycles later.
    logic [IADDR_W-1:0] mem_pipe [LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= a_inst;
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign d_inst = {{(32-IADDR_W-8){1'b0}}, mem_pipe[LAT-1], 8'hA5};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   c     = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        logic [31:0] r;
        r = {{(32-IADDR_W-8){1'b0}}, pc[IADDR_W+1:2], 8'hA5};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, c);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.pc   = start + 32'(4 * k);
            e.inst = inst_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    // Monitor: every accepted head is compared against the next expected entry.
    always @(negedge clk) begin
        if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got pc %h, required no output (cycle %0d)", out_pc, c);
            end else begin
                mon_e = exp_q.pop_front();
                $display("cycle %0d: out pc=%h inst=%h", c, out_pc, out_inst);
                check("out_pc", out_pc, mon_e.pc);
                check("out_inst", out_inst, mon_e.inst);
            end
        end
    end

    initial begin
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_a_inst", 32'(a_inst), 32'd0);

        // Streaming from reset, then a 10-cycle decode stall.
        push_seq(32'h0, 16);
        rstn      = 1'b1;
        out_ready = 1'b1;
        c         = 0;
        while (c < 3) begin
            check("first_lat_idle", 32'(out_valid), 32'd0);
            step();
        end
        while (c < 11) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b0;
        while (c < 21) begin
            check("stall_count", 32'(count), (c > 14) ? 32'd4 : 32'(c - 10));
            check("stall_hold_pc", out_pc, 32'h20);
            step();
        end
        check("stall_hold_inst", out_inst, inst_of(32'h20));
        out_ready = 1'b1;
        while (c < 29) step();

        // Redirect with two entries queued and two reads in flight.
        push_seq(32'h100, 9);
        out_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect  = 1'b0;
        out_ready = 1'b1;
        check("redir_valid_drop", 32'(out_valid), 32'd0);
        check("redir_a_inst", 32'(a_inst), 32'h40);
        step();
        check("redir_idle1", 32'(out_valid), 32'd0);
        step();
        check("redir_idle2", 32'(out_valid), 32'd0);
        step();
        check("redir_first_valid", 32'(out_valid), 32'd1);
        check("redir_first_pc", out_pc, 32'h100);
        while (c < 41) step();

        // Redirect coinciding with an accepted pop, unaligned target.
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        push_seq(32'h200, 5);
        step();
        redirect = 1'b0;
        check("pop_redir_valid_drop", 32'(out_valid), 32'd0);
        check("pop_redir_a_inst", 32'(a_inst), 32'h80);
        step();
        check("pop_redir_idle1", 32'(out_valid), 32'd0);
        step();
        check("pop_redir_idle2", 32'(out_valid), 32'd0);
        step();
        check("pop_redir_first_pc", out_pc, 32'h200);
        check("pop_redir_first_valid", 32'(out_valid), 32'd1);
        while (c < 49) step();

        // Redirect to the last word: fetch PC and address wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_seq(32'hFFFF_FFFC, 4);
        step();
        redirect = 1'b0;
        check("wrap_a_inst0", 32'(a_inst), 32'h7FFF);
        check("wrap_valid_drop", 32'(out_valid), 32'd0);
        step();
        check("wrap_a_inst1", 32'(a_inst), 32'h0000);
        step();
        check("wrap_a_inst2", 32'(a_inst), 32'h0001);
        step();
        check("wrap_first_pc", out_pc, 32'hFFFF_FFFC);
        while (c < 57) step();
        out_ready = 1'b0;
        repeat (3) step();
        check("drain_before_reset", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of operation discards queued and in-flight work.
        rstn = 1'b0;
        step();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_a_inst", 32'(a_inst), 32'd0);
        push_seq(32'h0, 4);
        rstn      = 1'b1;
        out_ready = 1'b1;
        c         = 0;
        while (c < 3) begin
            check("rst2_lat_idle", 32'(out_valid), 32'd0);
            step();
        end
        check("rst2_first_valid", 32'(out_valid), 32'd1);
        check("rst2_first_pc", out_pc, 32'h0);
        while (c < 7) step();
        out_ready = 1'b0;
        repeat (3) step();
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
